rf_dump: RTL and testbench

Hardware register-file dump engine for the multicycle CPU. On a start request it walks architectural registers r0..r31 through a dedicated combinational read port of the register file. Each register is emitted as an index/data beat on a valid/ready stream for the debug/trace path, so the simulation-only register printout is no longer needed. It also snoops the register-file write port and flags a dump that a concurrent write may have invalidated.

---
 rtl/rf_dump.sv | 102 ++++++++++
 tb/tb_rf_dump.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump.sv
// Walks r0..r31 through the register-file dump port and emits each as an idx/data beat.
// Latency: first beat two cycles after start is accepted, then one beat per two cycles (one per skipped register).
// Backpressure: a beat is held stable while out_ready is low; the walk resumes after the handshake.
module rf_dump #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    input  logic              mon_we,
    input  logic [ADDR_W-1:0] mon_wa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              dirty
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              at_last;
    logic              skip;
    logic              wr_hit;

    assign at_last = (ptr == LAST_IDX);
    // The final register is always emitted so the consumer always sees out_last.
    assign skip    = (SKIP_ZERO != 0) && (rf_rd == '0) && !at_last;
    assign wr_hit  = ((state == READ) || (state == HOLD)) && mon_we &&
                     (mon_wa != '0) && (mon_wa <= ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            out_idx  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            dirty    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr <= '0;
                    end
                end
                READ: begin
                    if (skip) begin
                        ptr <= ptr + 1'b1;
                    end else begin
                        out_data <= rf_rd;
                        out_idx  <= ptr;
                        out_last <= at_last;
                    end
                end
                HOLD: begin
                    if (out_ready && !at_last) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if ((state == IDLE) && start) begin
                dirty <= 1'b0;
            end else if (wr_hit) begin
                dirty <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: if (!skip) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = at_last ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == HOLD);
        done      = (state == DONE);
        rf_ra     = (state == READ) ? ptr : '0;
    end

endmodule

// File: tb/tb_rf_dump.sv
// Scoreboard bench for rf_dump: stimulus pushes expected beats, per-DUT monitors pop and compare on handshakes.
module tb_rf_dump;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mon_we = 1'b0;
    logic [4:0]  mon_wa = '0;

    logic        start = 1'b0, out_ready = 1'b1;
    logic        busy, out_valid, out_last, done, dirty;
    logic [4:0]  rf_ra, out_idx;
    logic [31:0] rf_rd, out_data;
    logic [31:0] rf [32];

    logic        s_start = 1'b0, s_ready = 1'b1;
    logic        s_busy, s_valid, s_last, s_done, s_dirty;
    logic [4:0]  s_ra, s_idx;
    logic [31:0] s_rd, s_data;
    logic [31:0] rf_s [32];

    beat_t q[$];
    beat_t qs[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    assign rf_rd = rf[rf_ra];
    assign s_rd  = rf_s[s_ra];

    rf_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .rf_ra(rf_ra), .rf_rd(rf_rd),
        .mon_we(mon_we), .mon_wa(mon_wa), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last), .done(done), .dirty(dirty)
    );

    rf_dump #(.ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .rf_ra(s_ra), .rf_rd(s_rd),
        .mon_we(mon_we), .mon_wa(mon_wa), .out_valid(s_valid), .out_ready(s_ready),
        .out_idx(s_idx), .out_data(s_data), .out_last(s_last), .done(s_done), .dirty(s_dirty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: one pop per accepted beat.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {59'd0, out_idx}, 64'h1_0000);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_idx", {59'd0, out_idx}, {59'd0, e.idx});
                chk("beat_data", {32'd0, out_data}, {32'd0, e.data});
                chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_valid === 1'b1 && s_ready === 1'b1) begin
            if (qs.size() == 0) begin
                chk("skip_unexpected_beat", {59'd0, s_idx}, 64'h1_0000);
            end else begin
                beat_t e;
                e = qs.pop_front();
                chk("skip_beat_idx", {59'd0, s_idx}, {59'd0, e.idx});
                chk("skip_beat_data", {32'd0, s_data}, {32'd0, e.data});
                chk("skip_beat_last", {63'd0, s_last}, {63'd0, e.last});
            end
        end
    end

    task automatic push_full();
        for (int i = 0; i < 32; i++) begin
            beat_t b;
            b.idx  = 5'(i);
            b.data = 32'(i) * 32'h01010101;
            b.last = (i == 31);
            q.push_back(b);
        end
    endtask

    // Pulse start before an edge; returns just after the accepting edge.
    task automatic start_dump(input bit sel);
        if (sel) s_start = 1'b1;
        else     start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        s_start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; exp_cyc < 0 skips the timing check.
    task automatic wait_done(input bit sel, input int exp_cyc, input int exp_first);
        int cyc;
        int first;
        bit seen;
        cyc   = 0;
        first = -1;
        seen  = 0;
        while (cyc < 300 && !seen) begin
            @(negedge clk);
            cyc++;
            if (first < 0 && (sel ? s_valid : out_valid)) first = cyc;
            if (sel ? s_done : done) seen = 1;
        end
        chk(sel ? "skip_done_seen" : "done_seen", {63'd0, seen}, 64'd1);
        if (exp_cyc >= 0) chk(sel ? "skip_done_cycle" : "done_cycle", 64'(cyc), 64'(exp_cyc));
        if (exp_first >= 0) chk("first_valid_cycle", 64'(first), 64'(exp_first));
        @(negedge clk);
        chk(sel ? "skip_busy_after_done" : "busy_after_done",
            {62'd0, sel ? s_busy : busy, sel ? s_done : done}, 64'd0);
    endtask

    task automatic wait_beat(input logic [4:0] idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_idx == idx) && n < 200);
        chk("reach_beat", {59'd0, out_idx}, {59'd0, idx});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]   = 32'(i) * 32'h01010101;
            rf_s[i] = '0;
        end
        rf_s[3] = 32'hDEADBEEF;

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #12 rst = 1'b1;
        #1;
        chk("reset_outputs", {46'd0, busy, out_valid, rf_ra, out_idx, out_last, done, dirty},
            64'd0);
        chk("reset_data", {32'd0, out_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_no_start", {62'd0, busy, out_valid}, 64'd0);

        // Full dump with ready held high.
        push_full();
        start_dump(0);
        wait_done(0, 65, 2);
        chk("full_dirty", {63'd0, dirty}, 64'd0);
        chk("full_queue_empty", 64'(q.size()), 64'd0);

        // Backpressure at beat 5 with a second start that must be ignored.
        push_full();
        start_dump(0);
        wait_beat(5'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {26'd0, out_valid, out_idx, out_data}, {26'd0, 1'b1, 5'd5, 32'h05050505});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(0, -1, -1);
        repeat (3) @(negedge clk);
        chk("bp_no_restart", {63'd0, busy}, 64'd0);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Write to an already-read register sets dirty, which survives done.
        push_full();
        start_dump(0);
        wait_beat(5'd10);
        mon_we = 1'b1;
        mon_wa = 5'd2;
        @(posedge clk);
        #1;
        mon_we = 1'b0;
        @(negedge clk);
        chk("dirty_set", {63'd0, dirty}, 64'd1);
        wait_done(0, -1, -1);
        repeat (2) @(negedge clk);
        chk("dirty_held", {63'd0, dirty}, 64'd1);

        // Write ahead of the pointer: clean, and the new start clears dirty.
        push_full();
        start_dump(0);
        @(negedge clk);
        chk("dirty_cleared_by_start", {63'd0, dirty}, 64'd0);
        wait_beat(5'd10);
        mon_we = 1'b1;
        mon_wa = 5'd20;
        @(posedge clk);
        #1;
        mon_we = 1'b0;
        wait_done(0, -1, -1);
        chk("dirty_ahead", {63'd0, dirty}, 64'd0);

        // r0 writes throughout a dump never dirty it.
        push_full();
        mon_we = 1'b1;
        mon_wa = 5'd0;
        start_dump(0);
        wait_done(0, 65, 2);
        mon_we = 1'b0;
        chk("dirty_r0", {63'd0, dirty}, 64'd0);

        // Reset while beat 10 is pending drops it; the next dump starts at r0.
        push_full();
        start_dump(0);
        wait_beat(5'd10);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {52'd0, busy, out_valid, out_idx, out_last, done}, 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_full();
        start_dump(0);
        wait_done(0, 65, 2);
        chk("post_rst_queue_empty", 64'(q.size()), 64'd0);

        // SKIP_ZERO: only r3 and r31 are emitted.
        begin
            beat_t b;
            b.idx = 5'd3;  b.data = 32'hDEADBEEF; b.last = 1'b0;
            qs.push_back(b);
            b.idx = 5'd31; b.data = 32'h0;        b.last = 1'b1;
            qs.push_back(b);
        end
        start_dump(1);
        wait_done(1, 35, -1);
        chk("skip_queue_empty", 64'(qs.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
